// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth recoding helper for the multiplier sequencer
package booth_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} booth_state_t;

    typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Q_1}
    function automatic booth_op_t booth_recode(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// rtl/booth_seq_ctrl_if.sv - operand/start/result handshake bundle for the Booth sequencer
interface booth_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                   start_i;
    logic                   abort_i;
    logic [WIDTH-1:0]       a_i;
    logic [WIDTH-1:0]       b_i;
    logic                   ready_o;
    logic                   busy_o;
    logic                   done_o;
    logic [2*WIDTH-1:0]     product_o;

    // Front end driving operands and requests
    modport master (
        output start_i, abort_i, a_i, b_i,
        input  ready_o, busy_o, done_o, product_o
    );

    // Sequencer side
    modport slave (
        input  start_i, abort_i, a_i, b_i,
        output ready_o, busy_o, done_o, product_o
    );
endinterface

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one Booth iteration: add/subtract multiplicand then arithmetic shift
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH:0]   m_i,
    input  booth_op_t        op_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q_1_o
);

    logic [WIDTH:0] sum;

    // Partial-product update followed by a 1-bit arithmetic right shift of {ACC,Q,Q_1};
    // the old Q_1 is always shifted out, so it is not needed here
    always_comb begin
        sum = acc_i;
        case (op_i)
            ADD:     sum = acc_i + m_i;
            SUB:     sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
        acc_o = {sum[WIDTH], sum[WIDTH:1]};
        q_o   = {sum[0], q_i[WIDTH-1:1]};
        q_1_o = q_i[0];
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - radix-2 Booth multiplier sequencer with start/abort/done handshake
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    booth_seq_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    booth_state_t       state;
    logic [WIDTH:0]     m_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   q_q;
    logic               q1_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH:0]     acc_n;
    logic [WIDTH-1:0]   q_n;
    logic               q1_n;
    booth_op_t          op;

    assign op = booth_recode(q_q[0], q1_q);

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .m_i   (m_q),
        .op_i  (op),
        .acc_o (acc_n),
        .q_o   (q_n),
        .q_1_o (q1_n)
    );

    assign bus.ready_o   = ready_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.product_o = product_q;

    // Sequencer FSM; the product and done pulse are registered on the last STEP edge so
    // that done_o coincides with the DONE state and ready_o returns the cycle after
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // abort has priority over a simultaneous start
                    if (bus.start_i && !bus.abort_i) begin
                        state   <= LOAD;
                        m_q     <= {bus.a_i[WIDTH-1], bus.a_i};
                        q_q     <= bus.b_i;
                        acc_q   <= '0;
                        q1_q    <= 1'b0;
                        cnt_q   <= CNT_W'(WIDTH);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.abort_i) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (bus.abort_i) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_n;
                        q_q   <= q_n;
                        q1_q  <= q1_n;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state     <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            product_q <= {acc_n[WIDTH-1:0], q_n};
                        end
                    end
                end
                DONE: begin
                    // result already delivered; abort has nothing left to cancel
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - self-checking bench for booth_seq_ctrl against a signed-multiply model
module tb_booth_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 2;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [15:0] last_prod;

    booth_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    booth_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete operation observed every cycle; optionally keeps start_i high and
    // scrambles the operands after acceptance, which must not disturb the result
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input bit hold);
        logic [15:0] exp;
        exp = ref_mul(a, b);
        @(negedge clk);
        check("ready_before", {15'd0, bus.ready_o}, 16'd1);
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.abort_i = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    bus.a_i = 8'($urandom);
                    bus.b_i = 8'($urandom);
                end else begin
                    bus.start_i = 1'b0;
                end
            end
            check("done_seq",  {15'd0, bus.done_o},  {15'd0, (k == LAT)});
            check("busy_seq",  {15'd0, bus.busy_o},  {15'd0, (k < LAT)});
            check("ready_seq", {15'd0, bus.ready_o}, 16'd0);
        end
        check("product", bus.product_o, exp);
        @(negedge clk);
        check("ready_after", {15'd0, bus.ready_o}, 16'd1);
        check("done_after",  {15'd0, bus.done_o},  16'd0);
        bus.start_i = 1'b0;
        last_prod = exp;
        if (hold) begin
            @(negedge clk);
            check("no_queue_busy", {15'd0, bus.busy_o}, 16'd0);
            check("no_queue_prod", bus.product_o, exp);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        last_prod   = '0;
        rst         = 1'b0;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", {15'd0, bus.ready_o}, 16'd1);
        check("rst_busy",  {15'd0, bus.busy_o},  16'd0);
        check("rst_done",  {15'd0, bus.done_o},  16'd0);
        check("rst_prod",  bus.product_o, 16'h0000);
        rst = 1'b1;

        do_mul(8'd3, 8'd5, 1'b0);
        check("lit_3x5", bus.product_o, 16'h000F);
        do_mul(8'h80, 8'h80, 1'b0);
        check("lit_m128sq", bus.product_o, 16'h4000);
        do_mul(8'd127, 8'h80, 1'b0);
        check("lit_127xm128", bus.product_o, 16'hC080);
        do_mul(8'd0, 8'hFF, 1'b0);
        check("lit_0xm1", bus.product_o, 16'h0000);
        do_mul(8'hFF, 8'hFF, 1'b0);
        check("lit_m1xm1", bus.product_o, 16'h0001);

        // start held through a whole operation with operands changing underneath
        do_mul(8'd11, 8'hF3, 1'b1);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        bus.a_i     = 8'd9;
        bus.b_i     = 8'd9;
        @(negedge clk);
        check("sa_ready", {15'd0, bus.ready_o}, 16'd1);
        check("sa_busy",  {15'd0, bus.busy_o},  16'd0);
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;

        // abort in LOAD
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("load_busy", {15'd0, bus.busy_o}, 16'd1);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("abl_ready", {15'd0, bus.ready_o}, 16'd1);
        check("abl_busy",  {15'd0, bus.busy_o},  16'd0);
        check("abl_prod",  bus.product_o, last_prod);

        // abort in the fourth STEP cycle
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 8'd100;
        bus.b_i     = 8'd77;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("abs_ready", {15'd0, bus.ready_o}, 16'd1);
        check("abs_busy",  {15'd0, bus.busy_o},  16'd0);
        for (int k = 0; k < 6; k++) begin
            check("abs_done", {15'd0, bus.done_o}, 16'd0);
            @(negedge clk);
        end
        check("abs_prod", bus.product_o, last_prod);
        do_mul(8'd6, 8'd7, 1'b0);
        check("lit_6x7", bus.product_o, 16'h002A);

        // abort in DONE is ignored
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 8'd9;
        bus.b_i     = 8'hF9;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        check("abd_done", {15'd0, bus.done_o}, 16'd1);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("abd_ready", {15'd0, bus.ready_o}, 16'd1);
        check("abd_prod",  bus.product_o, ref_mul(8'd9, 8'hF9));

        // asynchronous reset in the middle of STEP
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 8'd50;
        bus.b_i     = 8'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        check("arst_ready", {15'd0, bus.ready_o}, 16'd1);
        check("arst_busy",  {15'd0, bus.busy_o},  16'd0);
        check("arst_done",  {15'd0, bus.done_o},  16'd0);
        check("arst_prod",  bus.product_o, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        do_mul(8'd2, 8'hFD, 1'b0);
        check("lit_2xm3", bus.product_o, 16'hFFFA);

        // randomized operands against the reference multiply
        for (int i = 0; i < 16; i++) begin
            do_mul(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
